// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back stage: result select, load sizes, default width.
package wb_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;
    localparam int unsigned REG_AW       = 5;

    typedef enum logic [1:0] {
        RES_ALU  = 2'b00,
        RES_LOAD = 2'b01,
        RES_PC4  = 2'b10,
        RES_RSVD = 2'b11
    } result_src_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/writeback_unit_if.sv
// M/W pipeline inputs, long-latency result handshake and the GPR write port of the write-back stage.
interface writeback_unit_if #(
    parameter int unsigned XLEN  = wb_pkg::XLEN_DEFAULT,
    parameter int unsigned CNT_W = 64
);
    logic                      M_valid;
    logic [XLEN-1:0]           M_alu_result;
    logic [XLEN-1:0]           M_read_data;
    logic [XLEN-1:0]           M_pc_plus4;
    logic [wb_pkg::REG_AW-1:0] M_rd_addr;
    logic [1:0]                M_result_src;
    logic [2:0]                M_funct3;
    logic                      M_gpr_wen;
    logic                      W_stall;
    logic                      W_flush;
    logic                      X_valid;
    logic [wb_pkg::REG_AW-1:0] X_rd_addr;
    logic [XLEN-1:0]           X_data;
    logic                      X_ready;
    logic [wb_pkg::REG_AW-1:0] W_rd_addr;
    logic [XLEN-1:0]           W_rd;
    logic                      W_gpr_wen;
    logic [CNT_W-1:0]          W_instret;

    modport master (
        output M_valid, M_alu_result, M_read_data, M_pc_plus4, M_rd_addr,
               M_result_src, M_funct3, M_gpr_wen, W_stall, W_flush,
               X_valid, X_rd_addr, X_data,
        input  X_ready, W_rd_addr, W_rd, W_gpr_wen, W_instret
    );

    modport slave (
        input  M_valid, M_alu_result, M_read_data, M_pc_plus4, M_rd_addr,
               M_result_src, M_funct3, M_gpr_wen, W_stall, W_flush,
               X_valid, X_rd_addr, X_data,
        output X_ready, W_rd_addr, W_rd, W_gpr_wen, W_instret
    );
endinterface

// File: rtl/load_extend.sv
// Picks the addressed byte/halfword out of a raw memory word and sign- or zero-extends it.
module load_extend
    import wb_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN-1:0] raw,
    input  logic [1:0]      offset,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data
);
    logic [7:0]  byte_c;
    logic [15:0] half_c;

    // Halfword lane comes from offset[1] only; offset[0] misalignment is trapped upstream.
    always_comb begin
        byte_c = 8'(raw >> {offset, 3'b000});
        half_c = 16'(raw >> {offset[1], 4'b0000});
        data   = raw;
        case (funct3)
            F3_LB:   data = {{(XLEN-8){byte_c[7]}}, byte_c};
            F3_LBU:  data = {{(XLEN-8){1'b0}}, byte_c};
            F3_LH:   data = {{(XLEN-16){half_c[15]}}, half_c};
            F3_LHU:  data = {{(XLEN-16){1'b0}}, half_c};
            F3_LW:   data = raw;
            default: data = raw;
        endcase
    end
endmodule

// File: rtl/writeback_unit.sv
// Write-back stage: M/W register, result select, load extension, GPR write-port arbitration
// between the in-order pipeline and the long-latency unit, and the retired-instruction counter.
module writeback_unit
    import wb_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEFAULT,
    parameter int unsigned CNT_W = 64
) (
    input  logic             clk,
    input  logic             reset,
    writeback_unit_if.slave  bus
);
    logic              w_valid_q;
    logic              w_wen_q;
    logic [REG_AW-1:0] w_rd_addr_q;
    result_src_t       w_src_q;
    logic [2:0]        w_funct3_q;
    logic [XLEN-1:0]   w_alu_q;
    logic [XLEN-1:0]   w_raw_q;
    logic [XLEN-1:0]   w_pc4_q;
    logic [CNT_W-1:0]  instret_q;

    logic              m_take_c;
    logic              m_writes_c;
    logic [XLEN-1:0]   load_data_c;
    logic [XLEN-1:0]   result_c;

    assign m_take_c   = bus.M_valid & ~bus.W_flush;
    assign m_writes_c = m_take_c & bus.M_gpr_wen & (bus.M_rd_addr != '0);

    // Pipeline always wins the slot; an X result carries its data in the ALU field.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_valid_q   <= 1'b0;
            w_wen_q     <= 1'b0;
            w_rd_addr_q <= '0;
            w_src_q     <= RES_ALU;
            w_funct3_q  <= '0;
            w_alu_q     <= '0;
            w_raw_q     <= '0;
            w_pc4_q     <= '0;
            instret_q   <= '0;
        end else if (!bus.W_stall) begin
            if (w_valid_q) begin
                instret_q <= instret_q + CNT_W'(1);
            end
            if (m_take_c) begin
                w_valid_q   <= 1'b1;
                w_wen_q     <= m_writes_c;
                w_rd_addr_q <= bus.M_rd_addr;
                w_src_q     <= result_src_t'(bus.M_result_src);
                w_funct3_q  <= bus.M_funct3;
                w_alu_q     <= bus.M_alu_result;
                w_raw_q     <= bus.M_read_data;
                w_pc4_q     <= bus.M_pc_plus4;
            end else if (bus.X_valid) begin
                w_valid_q   <= 1'b0;
                w_wen_q     <= (bus.X_rd_addr != '0);
                w_rd_addr_q <= bus.X_rd_addr;
                w_src_q     <= RES_ALU;
                w_funct3_q  <= '0;
                w_alu_q     <= bus.X_data;
                w_raw_q     <= '0;
                w_pc4_q     <= '0;
            end else begin
                w_valid_q   <= 1'b0;
                w_wen_q     <= 1'b0;
                w_rd_addr_q <= '0;
                w_src_q     <= RES_ALU;
                w_funct3_q  <= '0;
                w_alu_q     <= '0;
                w_raw_q     <= '0;
                w_pc4_q     <= '0;
            end
        end
    end

    load_extend #(.XLEN(XLEN)) u_load_extend (
        .raw    (w_raw_q),
        .offset (w_alu_q[1:0]),
        .funct3 (w_funct3_q),
        .data   (load_data_c)
    );

    always_comb begin
        result_c = w_alu_q;
        case (w_src_q)
            RES_LOAD: result_c = load_data_c;
            RES_PC4:  result_c = w_pc4_q;
            RES_RSVD: result_c = w_alu_q;
            default:  result_c = w_alu_q;
        endcase
    end

    assign bus.W_rd      = result_c;
    assign bus.W_rd_addr = w_rd_addr_q;
    assign bus.W_gpr_wen = w_wen_q;
    assign bus.W_instret = instret_q;
    assign bus.X_ready   = ~reset & ~bus.W_stall & ~m_take_c;
endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: directed scenarios with literal expectations plus randomized traffic
// compared every cycle against a behavioural model of the write-back slot and retire counter.
module tb_writeback_unit;
    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    writeback_unit_if #(.XLEN(32), .CNT_W(64)) bus ();
    writeback_unit_if #(.XLEN(32), .CNT_W(3))  bus_s ();

    writeback_unit #(.XLEN(32), .CNT_W(64)) dut   (.clk(clk), .reset(reset), .bus(bus));
    writeback_unit #(.XLEN(32), .CNT_W(3))  dut_s (.clk(clk), .reset(reset), .bus(bus_s));

    // Narrow-counter copy sees the same inputs so counter wrap is exercised.
    assign bus_s.M_valid      = bus.M_valid;
    assign bus_s.M_alu_result = bus.M_alu_result;
    assign bus_s.M_read_data  = bus.M_read_data;
    assign bus_s.M_pc_plus4   = bus.M_pc_plus4;
    assign bus_s.M_rd_addr    = bus.M_rd_addr;
    assign bus_s.M_result_src = bus.M_result_src;
    assign bus_s.M_funct3     = bus.M_funct3;
    assign bus_s.M_gpr_wen    = bus.M_gpr_wen;
    assign bus_s.W_stall      = bus.W_stall;
    assign bus_s.W_flush      = bus.W_flush;
    assign bus_s.X_valid      = bus.X_valid;
    assign bus_s.X_rd_addr    = bus.X_rd_addr;
    assign bus_s.X_data       = bus.X_data;

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic        e_wen  = 1'b0;
    logic [4:0]  e_addr = '0;
    logic [31:0] e_data = '0;
    logic        e_ret  = 1'b0;
    logic [63:0] e_cnt  = '0;
    logic        x_acc  = 1'b0;
    logic        xr_exp;

    assign xr_exp = !reset && !bus.W_stall && !(bus.M_valid && !bus.W_flush);

    function automatic logic [31:0] ref_result(input logic [1:0] src, input logic [2:0] f3,
                                               input logic [31:0] alu, input logic [31:0] raw,
                                               input logic [31:0] pc4);
        logic [31:0] b, h;
        b = (raw >> (8 * alu[1:0])) & 32'h0000_00FF;
        h = (raw >> (16 * alu[1])) & 32'h0000_FFFF;
        if (src == 2'b10) return pc4;
        if (src != 2'b01) return alu;
        case (f3)
            3'b000:  return (b >= 32'h80)   ? (b | 32'hFFFF_FF00) : b;
            3'b100:  return b;
            3'b001:  return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
            3'b101:  return h;
            default: return raw;
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            e_wen <= 1'b0; e_addr <= '0; e_data <= '0; e_ret <= 1'b0; e_cnt <= '0; x_acc <= 1'b0;
        end else begin
            x_acc <= bus.X_valid && xr_exp;
            if (!bus.W_stall) begin
                if (e_ret) e_cnt <= e_cnt + 64'd1;
                if (bus.M_valid && !bus.W_flush) begin
                    e_ret  <= 1'b1;
                    e_addr <= bus.M_rd_addr;
                    e_wen  <= bus.M_gpr_wen && (bus.M_rd_addr != 5'd0);
                    e_data <= ref_result(bus.M_result_src, bus.M_funct3, bus.M_alu_result,
                                         bus.M_read_data, bus.M_pc_plus4);
                end else if (bus.X_valid) begin
                    e_ret  <= 1'b0;
                    e_addr <= bus.X_rd_addr;
                    e_wen  <= (bus.X_rd_addr != 5'd0);
                    e_data <= bus.X_data;
                end else begin
                    e_ret <= 1'b0; e_addr <= '0; e_wen <= 1'b0; e_data <= '0;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        chk("cyc_wen",     64'(bus.W_gpr_wen), 64'(e_wen));
        chk("cyc_addr",    64'(bus.W_rd_addr), 64'(e_addr));
        chk("cyc_rd",      64'(bus.W_rd),      64'(e_data));
        chk("cyc_instret", bus.W_instret,      e_cnt);
        chk("cyc_instret3", 64'(bus_s.W_instret), 64'(e_cnt[2:0]));
        chk("cyc_xready",  64'(bus.X_ready),   64'(xr_exp));
    end

    // ---------------- stimulus ----------------
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.M_valid = 1'b0; bus.M_alu_result = '0; bus.M_read_data = '0; bus.M_pc_plus4 = '0;
        bus.M_rd_addr = '0; bus.M_result_src = '0; bus.M_funct3 = '0; bus.M_gpr_wen = 1'b0;
        bus.W_stall = 1'b0; bus.W_flush = 1'b0;
    endtask

    task automatic set_m(input logic [31:0] alu, input logic [31:0] raw, input logic [31:0] pc4,
                         input logic [4:0] rd, input logic [1:0] src, input logic [2:0] f3,
                         input logic wen);
        bus.M_valid = 1'b1; bus.M_alu_result = alu; bus.M_read_data = raw; bus.M_pc_plus4 = pc4;
        bus.M_rd_addr = rd; bus.M_result_src = src; bus.M_funct3 = f3; bus.M_gpr_wen = wen;
        bus.W_stall = 1'b0; bus.W_flush = 1'b0;
    endtask

    function automatic logic [4:0] rnd_rd();
        return ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
    endfunction

    logic [63:0] v;
    logic        x_pend;
    logic [4:0]  x_rd;
    logic [31:0] x_dat;

    initial begin
        idle();
        bus.X_valid = 1'b0; bus.X_rd_addr = '0; bus.X_data = '0;
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rst_wen", 64'(bus.W_gpr_wen), 64'd0);
        chk("rst_rd", 64'(bus.W_rd), 64'd0);
        chk("rst_addr", 64'(bus.W_rd_addr), 64'd0);
        chk("rst_instret", bus.W_instret, 64'd0);
        chk("rst_xready", 64'(bus.X_ready), 64'd0);
        nxt();
        reset = 1'b0;

        // ALU result then loads
        set_m(32'h1234, 32'h0, 32'h0, 5'd3, 2'b00, 3'b000, 1'b1); nxt(); idle();
        @(negedge clk);
        chk("alu_rd", 64'(bus.W_rd), 64'h1234);
        chk("alu_addr", 64'(bus.W_rd_addr), 64'd3);
        chk("alu_wen", 64'(bus.W_gpr_wen), 64'd1);
        nxt();
        set_m(32'h1003, 32'h80FF_7F01, 32'h0, 5'd4, 2'b01, 3'b000, 1'b1); nxt(); idle();
        @(negedge clk);
        chk("lb_rd", 64'(bus.W_rd), 64'hFFFF_FF80);
        nxt();
        set_m(32'h1002, 32'h80FF_7F01, 32'h0, 5'd4, 2'b01, 3'b101, 1'b1); nxt(); idle();
        @(negedge clk);
        chk("lhu_rd", 64'(bus.W_rd), 64'h0000_80FF);
        nxt();

        // X waits behind three pipeline instructions
        bus.X_valid = 1'b1; bus.X_rd_addr = 5'd7; bus.X_data = 32'hDEAD;
        for (int i = 0; i < 3; i++) begin
            set_m(32'h100 + 32'(i), 32'h0, 32'h0, 5'd8, 2'b00, 3'b000, 1'b1);
            @(negedge clk);
            chk("arb_xready_busy", 64'(bus.X_ready), 64'd0);
            nxt();
        end
        idle();
        @(negedge clk);
        chk("arb_xready_free", 64'(bus.X_ready), 64'd1);
        nxt();
        bus.X_valid = 1'b0;
        @(negedge clk);
        chk("arb_rd", 64'(bus.W_rd), 64'hDEAD);
        chk("arb_addr", 64'(bus.W_rd_addr), 64'd7);
        chk("arb_wen", 64'(bus.W_gpr_wen), 64'd1);
        v = bus.W_instret;
        nxt();
        @(negedge clk);
        chk("arb_instret", bus.W_instret, v);
        nxt();

        // Flush and X together
        set_m(32'h999, 32'h0, 32'h0, 5'd9, 2'b00, 3'b000, 1'b1);
        bus.W_flush = 1'b1;
        bus.X_valid = 1'b1; bus.X_rd_addr = 5'd10; bus.X_data = 32'hBEEF;
        @(negedge clk);
        chk("flx_xready", 64'(bus.X_ready), 64'd1);
        v = bus.W_instret;
        nxt();
        idle(); bus.X_valid = 1'b0;
        @(negedge clk);
        chk("flx_rd", 64'(bus.W_rd), 64'hBEEF);
        chk("flx_addr", 64'(bus.W_rd_addr), 64'd10);
        nxt();
        @(negedge clk);
        chk("flx_instret", bus.W_instret, v);
        nxt();

        // Stall holding a JAL
        set_m(32'h0, 32'h0, 32'h104, 5'd1, 2'b10, 3'b000, 1'b1); nxt();
        idle(); bus.W_stall = 1'b1;
        bus.X_valid = 1'b1; bus.X_rd_addr = 5'd12; bus.X_data = 32'h777;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) v = bus.W_instret;
            else chk("stl_instret", bus.W_instret, v);
            chk("stl_rd", 64'(bus.W_rd), 64'h104);
            chk("stl_addr", 64'(bus.W_rd_addr), 64'd1);
            chk("stl_wen", 64'(bus.W_gpr_wen), 64'd1);
            chk("stl_xready", 64'(bus.X_ready), 64'd0);
            nxt();
        end
        bus.W_stall = 1'b0;
        @(negedge clk);
        chk("stl_xready_rel", 64'(bus.X_ready), 64'd1);
        nxt();
        bus.X_valid = 1'b0;
        @(negedge clk);
        chk("stl_instret_rel", bus.W_instret, v + 64'd1);
        chk("stl_xrd", 64'(bus.W_rd), 64'h777);
        nxt();

        // Write to x0
        set_m(32'h55, 32'h0, 32'h0, 5'd0, 2'b00, 3'b000, 1'b1); nxt(); idle();
        @(negedge clk);
        chk("x0_wen", 64'(bus.W_gpr_wen), 64'd0);
        nxt();

        // Randomized traffic; X inputs held until the model sees the handshake
        x_pend = 1'b0; x_rd = '0; x_dat = '0;
        for (int n = 0; n < 2000; n++) begin
            if (x_acc) x_pend = 1'b0;
            if (!x_pend && $urandom_range(0, 2) == 0) begin
                x_pend = 1'b1; x_rd = rnd_rd(); x_dat = $urandom;
            end
            bus.X_valid      = x_pend;
            bus.X_rd_addr    = x_pend ? x_rd : 5'($urandom);
            bus.X_data       = x_pend ? x_dat : $urandom;
            bus.M_valid      = 1'($urandom_range(0, 1));
            bus.M_alu_result = $urandom;
            bus.M_read_data  = $urandom;
            bus.M_pc_plus4   = $urandom;
            bus.M_rd_addr    = rnd_rd();
            bus.M_result_src = 2'($urandom);
            bus.M_funct3     = 3'($urandom);
            bus.M_gpr_wen    = ($urandom_range(0, 3) != 0);
            bus.W_flush      = ($urandom_range(0, 7) == 0);
            bus.W_stall      = ($urandom_range(0, 7) == 0);
            nxt();
        end
        idle(); bus.X_valid = 1'b0;
        nxt();

        // Reset mid-stream with ADDI x5=0x10 in W
        set_m(32'h10, 32'h0, 32'h0, 5'd5, 2'b00, 3'b000, 1'b1); nxt(); idle();
        #2;
        chk("mrst_pre_rd", 64'(bus.W_rd), 64'h10);
        reset = 1'b1;
        #1;
        chk("mrst_rd", 64'(bus.W_rd), 64'd0);
        chk("mrst_addr", 64'(bus.W_rd_addr), 64'd0);
        chk("mrst_wen", 64'(bus.W_gpr_wen), 64'd0);
        chk("mrst_instret", bus.W_instret, 64'd0);
        chk("mrst_xready", 64'(bus.X_ready), 64'd0);
        nxt();
        reset = 1'b0;

        // Eight retirements wrap the 3-bit counter to zero
        for (int i = 0; i < 8; i++) begin
            set_m($urandom, 32'h0, 32'h0, 5'(1 + i), 2'b00, 3'b000, 1'b1);
            nxt();
        end
        idle(); nxt();
        @(negedge clk);
        chk("wrap_small", 64'(bus_s.W_instret), 64'd0);
        chk("wrap_big", bus.W_instret, 64'd8);
        nxt();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
